axi_rx_fifo_channel: RTL and testbench
======================================

// Module: axi_rx_fifo_channel
// PURPOSE
//  Parametrised AXI-style receive channel: VALID/READY slave on the bus side, DEPTH-entry FIFO behind it.
//  Decouples bus beats from the upper module, which drains via its own valid/ready pair.
//  Replaces the single-latch rx_new_data/rx_hold scheme; sustains one beat per ACLK when not full.
// PARAMETERS
//  WIDTH  8  data bits per beat
//  DEPTH  4  FIFO entries; power of two, >= 2 (elaborate-time assertion)
// PORTS
//  ACLK         in   1           single clock; all logic on posedge ACLK
//  ARESETn      in   1           asynchronous, active-low reset
//  VALID        in   1           bus: transmitter has a beat
//  READY        out  1           bus: channel accepts a beat; registered, no path from VALID
//  xDATA        in   WIDTH       bus: incoming beat
//  rx_valid     out  1           upper: FIFO head valid (not empty)
//  rx_ready     in   1           upper: head consumed this cycle
//  rx_data      out  WIDTH       upper: FIFO head data
//  rx_flush     in   1           upper: synchronous clear of all stored beats
//  rx_level     out  $clog2(DEPTH)+1  occupancy (only with RX_LEVEL_EN)
//  rx_overflow  out  1           sticky: VALID seen while FIFO full (only with RX_LEVEL_EN)
// BEHAVIOUR
//  Reset: state=S_INIT, READY=0, rx_valid=0, rx_data=0, pointers/count=0, rx_level=0, rx_overflow=0.
//  FSM (registered), READY = (state==S_RUN):
//   S_INIT -> S_RUN after one clock, so READY is 0 for the first cycle after reset release.
//   S_RUN  -> S_FULL when next count == DEPTH; S_FULL -> S_RUN when next count < DEPTH.
//   Any state -> S_RUN on rx_flush (S_INIT also exits on flush).
//  push = VALID & READY: at that edge xDATA is written at wr_ptr; wr_ptr++; count++.
//  pop = rx_valid & rx_ready: rd_ptr++; count--. Push and pop in the same cycle leave count unchanged.
//  Latency: beat accepted at edge N appears on rx_data/rx_valid after edge N (first-word fall-through).
//  rx_data = mem[rd_ptr], combinational read of registered storage; held stable while rx_valid & !rx_ready.
//  Full: READY goes low the cycle after the push that fills the FIFO. A pop while full raises READY
//   one cycle later; no same-cycle refill. Each full/empty transition costs one bubble.
//  Empty: rx_valid=0, rx_ready ignored, count never underflows.
//  Pointers are ADDR_W=$clog2(DEPTH) bits and wrap naturally; count is ADDR_W+1 bits, range 0..DEPTH.
//  rx_flush: at that edge pointers/count=0 and rx_valid=0 next cycle. A push in the same cycle is discarded.
//   A pop in the same cycle is a no-op. READY=1 the next cycle.
//  VALID while READY=0 is not a transfer; the transmitter holds the beat (AXI rule). Nothing is lost.
//  ARESETn asserted mid-transfer: all contents dropped immediately, outputs go to reset values asynchronously.
// CONFIGURATION
//  RX_LEVEL_EN defined: rx_level = count (registered).
//   rx_overflow sets when VALID=1 & state==S_FULL; cleared only by reset or rx_flush.
//  RX_LEVEL_EN undefined: both ports are absent from the port list and the logic is not built.
//   Core FIFO behaviour is identical in both builds.
// STRUCTURE
//  Package axi_rx_pkg: typedef enum logic [1:0] {S_INIT, S_RUN, S_FULL} rx_state_t; localparam helper
//   for ADDR_W; shared with the future TX-side FIFO.
//  Sub-module rx_fifo_mem: DEPTH x WIDTH register array, one write port (we, waddr, wdata),
//   asynchronous read port (raddr, rdata), no reset on storage.
//  Top holds FSM, pointers, count and flags.
// TESTING
//  1 Reset: hold ARESETn=0 with VALID=1 -> READY=0, rx_valid=0; after release READY=0 one cycle, then 1.
//  2 Stream: DEPTH=4, VALID=1 with data 0x11..0x18, rx_ready=1 -> 8 beats out in order,
//    no stall after first, count never >1.
//  3 Fill: rx_ready=0, push 0xA1..0xA4 -> READY=0 after 4th edge; VALID with 0xA5 held;
//    single pop -> 0xA1 out, READY=1 next cycle, 0xA5 accepted.
//  4 Simultaneous: count=2, push 0x5C and pop in same cycle -> count stays 2, order preserved, 8+ cycles of wrap.
//  5 Flush: count=3, rx_flush=1 with concurrent push 0x77 -> next cycle rx_valid=0, 0x77 never delivered, READY=1.
//  6 RX_LEVEL_EN: fill to 4, hold VALID -> rx_level=4, rx_overflow=1 sticky until rx_flush; reset mid-fill -> rx_level=0.

Source files
------------

// File: rtl/axi_rx_pkg.sv
// Shared definitions for the AXI-style receive (and future transmit) FIFO channels.
package axi_rx_pkg;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FULL} rx_state_t;

  function automatic int rx_addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, asynchronous read, storage not reset.
module rx_fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_rx_fifo_channel.sv
// VALID/READY receive channel feeding a first-word-fall-through FIFO drained by the upper module.
// Optional build macro RX_LEVEL_EN adds the rx_level occupancy and sticky rx_overflow outputs.
module axi_rx_fifo_channel
  import axi_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    VALID,
  output logic                    READY,
  input  logic [WIDTH-1:0]        xDATA,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [WIDTH-1:0]        rx_data,
  input  logic                    rx_flush
`ifdef RX_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  rx_level,
  output logic                    rx_overflow
`endif
);

  localparam int ADDR_W = rx_addr_w(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("axi_rx_fifo_channel: DEPTH must be a power of two >= 2");
  end

  rx_state_t         state, state_nx;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_nx;
  logic [WIDTH-1:0]  rdata;
  logic              push, pop, we;

  assign READY    = (state == S_RUN);
  assign rx_valid = (count != '0);
  assign push     = VALID & READY;
  assign pop      = rx_valid & rx_ready;
  // A beat arriving with a flush is dropped, so it must not land in storage either.
  assign we       = push & ~rx_flush;

  always_comb begin
    count_nx = count;
    case ({push, pop})
      2'b10:   count_nx = count + CNT_ONE;
      2'b01:   count_nx = count - CNT_ONE;
      default: count_nx = count;
    endcase
  end

  // READY is derived from registered state only, so the bus never sees a VALID->READY path.
  always_comb begin
    state_nx = state;
    if (rx_flush) state_nx = S_RUN;
    else begin
      case (state)
        S_INIT:  state_nx = S_RUN;
        S_RUN:   if (count_nx == CNT_FULL) state_nx = S_FULL;
        S_FULL:  if (count_nx != CNT_FULL) state_nx = S_RUN;
        default: state_nx = S_INIT;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= S_INIT;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      if (rx_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        count <= count_nx;
      end
    end
  end

  rx_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (ACLK),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (xDATA),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Storage is unreset, so mask the head while empty to keep rx_data defined.
  assign rx_data = rx_valid ? rdata : '0;

`ifdef RX_LEVEL_EN
  logic ovf;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)                        ovf <= 1'b0;
    else if (rx_flush)                   ovf <= 1'b0;
    else if (VALID && state == S_FULL)   ovf <= 1'b1;
  end

  assign rx_level    = count;
  assign rx_overflow = ovf;
`endif

endmodule

// File: tb/tb_axi_rx_fifo_channel.sv
// Directed + randomized bench for axi_rx_fifo_channel, checked against a queue-based model.
module tb_axi_rx_fifo_channel;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             ACLK, ARESETn, VALID, READY, rx_valid, rx_ready, rx_flush;
  logic [WIDTH-1:0] xDATA, rx_data;
`ifdef RX_LEVEL_EN
  logic [$clog2(DEPTH):0] rx_level;
  logic                   rx_overflow;
`endif

  axi_rx_fifo_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .VALID    (VALID),
    .READY    (READY),
    .xDATA    (xDATA),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_flush (rx_flush)
`ifdef RX_LEVEL_EN
    ,
    .rx_level    (rx_level),
    .rx_overflow (rx_overflow)
`endif
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: ordered contents, bus readiness, post-reset warm-up flag, overflow flag.
  logic [WIDTH-1:0] q[$];
  logic             m_ready, m_init, m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_data;
    exp_data = (q.size() != 0) ? 32'(q[0]) : 32'h0;
    check({tag, ".READY"},    32'(READY),    32'(m_ready));
    check({tag, ".rx_valid"}, 32'(rx_valid), 32'(q.size() != 0));
    check({tag, ".rx_data"},  32'(rx_data),  exp_data);
`ifdef RX_LEVEL_EN
    check({tag, ".rx_level"},    32'(rx_level),    32'(q.size()));
    check({tag, ".rx_overflow"}, 32'(rx_overflow), 32'(m_ovf));
`endif
  endtask

  // Apply inputs for one edge, advance the model by the channel's rules, then compare.
  task automatic cycle(input string tag, input logic v, input logic [WIDTH-1:0] d,
                       input logic rr, input logic fl);
    logic push, pop;
    VALID = v; xDATA = d; rx_ready = rr; rx_flush = fl;
    push = v && m_ready;
    pop  = (q.size() != 0) && rr;
    if (v && !m_ready && !m_init) m_ovf = 1'b1;
    @(posedge ACLK);
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
    end
    m_ready = (q.size() < DEPTH);
    m_init  = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  task automatic reset_model();
    q.delete();
    m_ready = 1'b0;
    m_init  = 1'b1;
    m_ovf   = 1'b0;
  endtask

  // Assert reset between edges (asynchronous effect checked at once), release after two edges.
  task automatic do_reset(input string tag);
    ARESETn = 1'b0;
    #1;
    reset_model();
    check_outputs({tag, ".async"});
    repeat (2) @(posedge ACLK);
    #1;
    check_outputs({tag, ".held"});
    ARESETn = 1'b1;
    #1;
    check_outputs({tag, ".release"});
  endtask

  initial begin
    logic             hv, acc;
    logic [WIDTH-1:0] hd;

    ARESETn = 1'b0; VALID = 1'b1; xDATA = 8'h3C; rx_ready = 1'b0; rx_flush = 1'b0;
    reset_model();

    // 1: reset with VALID high; READY stays low for the first edge after release
    do_reset("reset");
    cycle("reset.first", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("reset.second", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("reset.drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // 2: continuous stream with the consumer always ready
    for (int i = 0; i < 8; i++) cycle("stream", 1'b1, 8'(8'h11 + i), 1'b1, 1'b0);
    cycle("stream.drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // 3: fill to full, held beat, single pop, refill one cycle later
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
    cycle("fill.hold", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("fill.hold", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("fill.pop", 1'b1, 8'hA5, 1'b1, 1'b0);
    cycle("fill.refill", 1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("fill.drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // 4: simultaneous push/pop at level 2, wrapping the pointers several times
    cycle("simul.pre", 1'b1, 8'h5A, 1'b0, 1'b0);
    cycle("simul.pre", 1'b1, 8'h5B, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle("simul", 1'b1, 8'(8'h5C + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("simul.drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // 5: flush at level 3 with a concurrent push that must be discarded
    for (int i = 0; i < 3; i++) cycle("flush.pre", 1'b1, 8'(8'h31 + i), 1'b0, 1'b0);
    cycle("flush", 1'b1, 8'h77, 1'b1, 1'b1);
    cycle("flush.after", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("flush.after", 1'b0, 8'h00, 1'b1, 1'b0);

    // 6: overflow stickiness (level outputs compared inside check_outputs when built)
    for (int i = 0; i < 4; i++) cycle("ovf.fill", 1'b1, 8'(8'hC1 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("ovf.hold", 1'b1, 8'hC5, 1'b0, 1'b0);
    cycle("ovf.pop", 1'b1, 8'hC5, 1'b1, 1'b0);
    cycle("ovf.sticky", 1'b1, 8'hC5, 1'b0, 1'b0);
    cycle("ovf.sticky", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("ovf.flush", 1'b0, 8'h00, 1'b0, 1'b1);
    cycle("ovf.clear", 1'b0, 8'h00, 1'b0, 1'b0);

    // Reset in the middle of filling drops everything asynchronously
    cycle("midrst.fill", 1'b1, 8'hE1, 1'b0, 1'b0);
    cycle("midrst.fill", 1'b1, 8'hE2, 1'b0, 1'b0);
    VALID = 1'b1; xDATA = 8'hE3;
    do_reset("midrst");
    VALID = 1'b0;
    cycle("midrst.first", 1'b0, 8'h00, 1'b0, 1'b0);

    // Randomized traffic from an AXI-compliant source that holds a beat until accepted
    hv = 1'b0; hd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 3) != 0);
        hd = 8'($urandom);
      end
      acc = hv && m_ready;
      cycle("rand", hv, hd, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      if (acc) hv = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
